// File: rtl/gcd_ctrl_pkg.sv
// Shared encodings for the GCD job sequencer: FSM states and display-mode codes.
package gcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [1:0] DISP_EDIT   = 2'd0;
  localparam logic [1:0] DISP_BUSY   = 2'd1;
  localparam logic [1:0] DISP_RESULT = 2'd2;
  localparam logic [1:0] DISP_ERR    = 2'd3;

  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] m;
    m = DISP_EDIT;
    case (s)
      ST_CLR, ST_START, ST_WAIT: m = DISP_BUSY;
      ST_DONE:                   m = DISP_RESULT;
      ST_ERROR:                  m = DISP_ERR;
      default:                   m = DISP_EDIT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gcd_result_watch.sv
// Watches the live CPU result and flags the cycle on which it has been
// non-zero and unchanged for STABLE_CYC consecutive cycles.
module gcd_result_watch #(
  parameter int STABLE_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_value,
  output logic        stable_hit
);

  localparam int SW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

  logic [31:0] r_prev;
  logic [SW-1:0] r_cnt;
  logic w_match;

  assign w_match    = (i_value != 32'd0) && (i_value == r_prev);
  // Fires on the cycle the counter would reach STABLE_CYC, so the caller can act on that edge.
  assign stable_hit = i_en && w_match && (r_cnt == SW'(STABLE_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 32'd0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_value;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        if (!w_match) begin
          r_cnt <= '0;
        end else if (r_cnt != SW'(STABLE_CYC - 1)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_job_ctrl.sv
// Front-panel job sequencer for the rv32i GCD datapath: clear, start, wait, report.
// Define GCD_JOB_CTRL_LAT_EN to add the lat_cycles latency counter output.
module gcd_job_ctrl
  import gcd_ctrl_pkg::*;
#(
  parameter int CLR_CYC     = 4,
  parameter int STABLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_start,
  input  logic        req_abort,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        cpu_rst_req,
  output logic        cpu_start,
  output logic [31:0] cpu_op_a,
  output logic [31:0] cpu_op_b,
  input  logic [31:0] cpu_result,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  result,
  output logic        edit_lock,
  output logic [1:0]  disp_mode
`ifdef GCD_JOB_CTRL_LAT_EN
  ,
  output logic [CNT_W-1:0] lat_cycles
`endif
);

  state_t r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [7:0] r_result, w_result_next;
  logic [7:0] r_op_a, r_op_b;
  logic [1:0] r_disp;
  logic w_start_ok, w_latch, w_stable_hit;

  assign w_start_ok = req_start &&
                      (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);

  gcd_result_watch #(.STABLE_CYC(STABLE_CYC)) u_watch (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == ST_START),
    .i_en       (r_state == ST_WAIT),
    .i_value    (cpu_result),
    .stable_hit (w_stable_hit)
  );

  // r_cnt is shared: CLR hold count, then timeout count once in WAIT.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_result_next = r_result;
    w_latch       = 1'b0;
    if (req_abort) begin
      w_state_next  = ST_IDLE;
      w_cnt_next    = '0;
      w_result_next = 8'd0;
    end else if (w_start_ok) begin
      w_latch    = 1'b1;
      w_cnt_next = '0;
      if (op_a == 8'd0 && op_b == 8'd0) begin
        w_state_next = ST_ERROR;
      end else if (op_a == 8'd0) begin
        w_result_next = op_b;
        w_state_next  = ST_DONE;
      end else if (op_b == 8'd0) begin
        w_result_next = op_a;
        w_state_next  = ST_DONE;
      end else begin
        w_state_next = ST_CLR;
      end
    end else begin
      case (r_state)
        ST_CLR: begin
          if (r_cnt == CNT_W'(CLR_CYC - 1)) begin
            w_state_next = ST_START;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        ST_START: begin
          w_state_next = ST_WAIT;
          w_cnt_next   = '0;
        end
        ST_WAIT: begin
          if (w_stable_hit) begin
            w_result_next = cpu_result[7:0];
            w_state_next  = ST_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_state_next = ST_ERROR;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_result <= 8'd0;
      r_op_a   <= 8'd0;
      r_op_b   <= 8'd0;
      r_disp   <= DISP_EDIT;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_result <= w_result_next;
      r_disp   <= disp_of(w_state_next);
      if (w_latch) begin
        r_op_a <= op_a;
        r_op_b <= op_b;
      end
    end
  end

  assign cpu_rst_req = (r_state == ST_CLR);
  assign cpu_start   = (r_state == ST_START);
  assign busy        = (r_state == ST_CLR) || (r_state == ST_START) || (r_state == ST_WAIT);
  assign done        = (r_state == ST_DONE);
  assign err         = (r_state == ST_ERROR);
  assign edit_lock   = busy;
  assign result      = r_result;
  assign disp_mode   = r_disp;
  assign cpu_op_a    = {24'd0, r_op_a};
  assign cpu_op_b    = {24'd0, r_op_b};

`ifdef GCD_JOB_CTRL_LAT_EN
  logic [CNT_W-1:0] r_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat <= '0;
    end else if (req_abort || w_start_ok) begin
      r_lat <= '0;
    end else if ((r_state == ST_START || r_state == ST_WAIT) && (r_lat != '1)) begin
      r_lat <= r_lat + 1'b1;
    end
  end

  assign lat_cycles = r_lat;
`endif

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Directed bench for gcd_job_ctrl with a behavioural CPU and an expected-result queue.
module tb_gcd_job_ctrl;

  localparam int CLR_CYC    = 4;
  localparam int STABLE_CYC = 8;
  localparam int TMO_CYC    = 100;
  localparam int CNT_W      = 20;
  localparam int CPU_LAT    = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_start = 1'b0;
  logic        req_abort = 1'b0;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        cpu_rst_req, cpu_start;
  logic [31:0] cpu_op_a, cpu_op_b;
  logic [31:0] cpu_result;
  logic        busy, done, err, edit_lock;
  logic [7:0]  result;
  logic [1:0]  disp_mode;
`ifdef GCD_JOB_CTRL_LAT_EN
  logic [CNT_W-1:0] lat_cycles;
`endif

  gcd_job_ctrl #(
    .CLR_CYC(CLR_CYC), .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TMO_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_abort(req_abort),
    .op_a(op_a), .op_b(op_b), .cpu_rst_req(cpu_rst_req), .cpu_start(cpu_start),
    .cpu_op_a(cpu_op_a), .cpu_op_b(cpu_op_b), .cpu_result(cpu_result),
    .busy(busy), .done(done), .err(err), .result(result),
    .edit_lock(edit_lock), .disp_mode(disp_mode)
`ifdef GCD_JOB_CTRL_LAT_EN
    , .lat_cycles(lat_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Behavioural CPU: mode 0 answers gcd, mode 1 glitches 4,0,4.., mode 2 never answers.
  int cpu_mode = 0;
  int cpu_cnt = 0;
  always @(posedge clk) begin
    if (rst || cpu_rst_req) begin
      cpu_cnt    <= 0;
      cpu_result <= 32'd0;
    end else begin
      if (cpu_start) cpu_cnt <= 1;
      else if (cpu_cnt != 0 && cpu_cnt < 1000) cpu_cnt <= cpu_cnt + 1;
      if (cpu_cnt == CPU_LAT - 1) begin
        if (cpu_mode == 0) cpu_result <= gcd(cpu_op_a, cpu_op_b);
        else if (cpu_mode == 1) cpu_result <= 32'd4;
      end
      if (cpu_mode == 1 && cpu_cnt == CPU_LAT) cpu_result <= 32'd0;
      if (cpu_mode == 1 && cpu_cnt == CPU_LAT + 1) cpu_result <= 32'd4;
    end
  end

  int n_start = 0;
  int n_clr = 0;
  always @(posedge clk) begin
    if (cpu_start) n_start <= n_start + 1;
    if (cpu_rst_req) n_clr <= n_clr + 1;
  end

  typedef struct {
    logic [7:0] res;
    logic       is_err;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
    op_a = a;
    op_b = b;
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask

  // Wait (bounded) for done/err, then pop the expected outcome and compare.
  task automatic run_and_check(input string tag, input int start_cyc);
    int cyc;
    exp_t e;
    cyc = start_cyc;
    while (!(done || err) && cyc < 2000) begin
      tick();
      cyc++;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_done"}, {31'd0, done}, {31'd0, ~e.is_err});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e.is_err});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_disp"}, {30'd0, disp_mode}, e.is_err ? 32'd3 : 32'd2);
    if (!e.is_err) check({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
`ifdef GCD_JOB_CTRL_LAT_EN
    check({tag, "_lat_cycles"}, {12'd0, lat_cycles},
          (e.lat > 1) ? 32'(e.lat - 1 - CLR_CYC) : 32'd0);
`endif
    $display("job %s: cycles=%0d done=%0b err=%0b result=%0d", tag, cyc, done, err, result);
  endtask

  int s0, c0;

  initial begin
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_disp", {30'd0, disp_mode}, 32'd0);
    check("rst_cpu_rst_req", {31'd0, cpu_rst_req}, 32'd0);
    check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check("rst_cpu_op_a", cpu_op_a, 32'd0);
    rst = 1'b0;
    tick();

    // Normal job 12,18
    s0 = n_start; c0 = n_clr;
    exp_q.push_back('{res: 8'd6, is_err: 1'b0, lat: 64});
    pulse_start(8'd12, 8'd18);
    check("clr_rst_req", {31'd0, cpu_rst_req}, 32'd1);
    check("clr_edit_lock", {31'd0, edit_lock}, 32'd1);
    check("clr_disp", {30'd0, disp_mode}, 32'd1);
    run_and_check("gcd_12_18", 1);
    check("gcd_12_18_op_a", cpu_op_a, 32'd12);
    check("gcd_12_18_op_b", cpu_op_b, 32'd18);
    check("gcd_12_18_starts", n_start - s0, 32'd1);
    check("gcd_12_18_clr_cycles", n_clr - c0, 32'd4);

    // Degenerate operands
    s0 = n_start;
    exp_q.push_back('{res: 8'd35, is_err: 1'b0, lat: 1});
    pulse_start(8'd0, 8'd35);
    run_and_check("zero_a", 1);
    check("zero_a_starts", n_start - s0, 32'd0);
    exp_q.push_back('{res: 8'd0, is_err: 1'b1, lat: 1});
    pulse_start(8'd0, 8'd0);
    run_and_check("zero_both", 1);

    // Glitching result restarts the stability count
    cpu_mode = 1;
    exp_q.push_back('{res: 8'd4, is_err: 1'b0, lat: 66});
    pulse_start(8'd8, 8'd12);
    run_and_check("glitch", 1);

    // CPU never answers
    cpu_mode = 2;
    exp_q.push_back('{res: 8'd0, is_err: 1'b1, lat: 1 + CLR_CYC + 1 + TMO_CYC});
    pulse_start(8'd9, 8'd6);
    run_and_check("timeout", 1);

    // req_start during WAIT is ignored
    cpu_mode = 0;
    s0 = n_start;
    exp_q.push_back('{res: 8'd5, is_err: 1'b0, lat: 64});
    pulse_start(8'd15, 8'd25);
    repeat (19) tick();
    check("ign_in_wait_busy", {31'd0, busy}, 32'd1);
    op_a = 8'd0; op_b = 8'd0;
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
    run_and_check("ign_start", 21);
    check("ign_start_starts", n_start - s0, 32'd1);
    check("ign_start_op_a", cpu_op_a, 32'd15);

    // Asynchronous reset in the middle of CLR
    pulse_start(8'd14, 8'd21);
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cpu_rst_req", {31'd0, cpu_rst_req}, 32'd0);
    check("arst_result", {24'd0, result}, 32'd0);
    check("arst_cpu_op_a", cpu_op_a, 32'd0);
    check("arst_disp", {30'd0, disp_mode}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    exp_q.push_back('{res: 8'd7, is_err: 1'b0, lat: 64});
    pulse_start(8'd14, 8'd21);
    run_and_check("after_rst", 1);

    // Abort with simultaneous start while waiting
    s0 = n_start;
    pulse_start(8'd12, 8'd18);
    repeat (19) tick();
    op_a = 8'd0; op_b = 8'd35;
    req_abort = 1'b1;
    req_start = 1'b1;
    tick();
    req_abort = 1'b0;
    req_start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_cpu_rst_req", {31'd0, cpu_rst_req}, 32'd0);
    check("abort_disp", {30'd0, disp_mode}, 32'd0);
    repeat (80) tick();
    check("abort_idle_done", {31'd0, done}, 32'd0);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    check("abort_starts", n_start - s0, 32'd1);
    $display("job abort: busy=%0b done=%0b result=%0d", busy, done, result);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
